// File: rtl/x3q_mem_arbiter_if.sv
// rtl/x3q_mem_arbiter_if.sv - requester and memory handshake bundle for x3q_mem_arbiter
interface x3q_mem_arbiter_if #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]        ch_req;
    logic [CHANNELS-1:0]        ch_type;
    logic [CHANNELS*ADDR_W-1:0] ch_addr;
    logic [CHANNELS*DATA_W-1:0] ch_wdata;
    logic [CHANNELS-1:0]        ch_grant;
    logic [CHANNELS-1:0]        ch_done;
    logic                       ch_error;
    logic [DATA_W-1:0]          ch_rdata;
    logic                       request;
    logic                       request_type;
    logic [ADDR_W-1:0]          request_address;
    logic [DATA_W-1:0]          data_out;
    logic [DATA_W-1:0]          memory_in;
    logic                       memory_ready;
    logic                       write_complete;
    logic                       memory_critical;

    // master = the arbiter; slave = requesters plus the memory they share
    modport master (
        input  ch_req, ch_type, ch_addr, ch_wdata,
        input  memory_in, memory_ready, write_complete, memory_critical,
        output ch_grant, ch_done, ch_error, ch_rdata,
        output request, request_type, request_address, data_out
    );

    modport slave (
        output ch_req, ch_type, ch_addr, ch_wdata,
        output memory_in, memory_ready, write_complete, memory_critical,
        input  ch_grant, ch_done, ch_error, ch_rdata,
        input  request, request_type, request_address, data_out
    );
endinterface

// File: rtl/x3q_mem_arbiter.sv
// rtl/x3q_mem_arbiter.sv - round-robin multi-master arbiter onto one x3q16 memory port
module x3q_mem_arbiter #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int CHANNELS = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    x3q_mem_arbiter_if.master    bus
);
    localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    win;
    logic [IDX_W-1:0]    cand;
    logic                win_valid;
    logic [CHANNELS-1:0] elig;
    logic                complete;
    logic                timed_out;
    logic [CNT_W-1:0]    tcnt;

    always_comb begin
        elig      = bus.memory_critical ? (bus.ch_req & CHANNELS'(1)) : bus.ch_req;
        win       = '0;
        win_valid = 1'b0;
        cand      = '0;
        // search starts one past the previous owner, so it is visited last
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % CHANNELS);
            if (!win_valid && elig[cand]) begin
                win_valid = 1'b1;
                win       = cand;
            end
        end

        // only the strobe matching the latched type finishes the transaction
        complete  = bus.request_type ? bus.write_complete : bus.memory_ready;
        timed_out = (TIMEOUT != 0) && (tcnt == CNT_W'(TO_LAST)) && !complete;

        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = BUSY;
            BUSY:    if (complete || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.request         <= 1'b0;
            bus.request_type    <= 1'b0;
            bus.request_address <= '0;
            bus.data_out        <= '0;
            bus.ch_grant        <= '0;
            bus.ch_done         <= '0;
            bus.ch_error        <= 1'b0;
            bus.ch_rdata        <= '0;
            last_grant          <= IDX_W'(CHANNELS - 1);
            tcnt                <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        bus.request         <= 1'b1;
                        bus.request_type    <= bus.ch_type[win];
                        bus.request_address <= bus.ch_addr[int'(win)*ADDR_W +: ADDR_W];
                        bus.data_out        <= bus.ch_wdata[int'(win)*DATA_W +: DATA_W];
                        bus.ch_grant        <= CHANNELS'(1) << win;
                        last_grant          <= win;
                        tcnt                <= '0;
                    end
                end
                BUSY: begin
                    tcnt <= tcnt + 1'b1;
                    if (complete || timed_out) begin
                        bus.request  <= 1'b0;
                        bus.ch_done  <= bus.ch_grant;
                        bus.ch_error <= timed_out;
                        if (complete && !bus.request_type)
                            bus.ch_rdata <= bus.memory_in;
                    end
                end
                DONE: begin
                    bus.ch_done  <= '0;
                    bus.ch_error <= 1'b0;
                    bus.ch_grant <= '0;
                end
                default: begin
                    bus.request  <= 1'b0;
                    bus.ch_done  <= '0;
                    bus.ch_error <= 1'b0;
                    bus.ch_grant <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_x3q_mem_arbiter.sv
// tb/tb_x3q_mem_arbiter.sv - scoreboard bench for x3q_mem_arbiter, two channels, TIMEOUT=4
module tb_x3q_mem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    x3q_mem_arbiter_if #(.DATA_W(16), .ADDR_W(16), .CHANNELS(2)) bus ();

    x3q_mem_arbiter #(.DATA_W(16), .ADDR_W(16), .CHANNELS(2), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          ch;
        bit          rd;
        logic [15:0] rdata;
        bit          err;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.ch_done !== 2'b00) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_done ch_done=%b expected none", bus.ch_done);
            end else begin
                mon_e = sbq.pop_front();
                total++;
                if (bus.ch_done !== (2'b01 << mon_e.ch)) begin
                    bad++;
                    $display("FAIL sb_done_owner got=%b exp=%b", bus.ch_done, 2'b01 << mon_e.ch);
                end
                total++;
                if (bus.ch_error !== mon_e.err) begin
                    bad++;
                    $display("FAIL sb_error got=%b exp=%b", bus.ch_error, mon_e.err);
                end
                if (mon_e.rd) begin
                    total++;
                    if (bus.ch_rdata !== mon_e.rdata) begin
                        bad++;
                        $display("FAIL sb_rdata got=%h exp=%h", bus.ch_rdata, mon_e.rdata);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ch_req          = '0;
        bus.ch_type         = '0;
        bus.ch_addr         = '0;
        bus.ch_wdata        = '0;
        bus.memory_in       = '0;
        bus.memory_ready    = 1'b0;
        bus.write_complete  = 1'b0;
        bus.memory_critical = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        cyc();
        total++; if (bus.request !== 1'b0) begin bad++; $display("FAIL rst_request got=%b exp=0", bus.request); end
        total++; if (bus.request_type !== 1'b0) begin bad++; $display("FAIL rst_type got=%b exp=0", bus.request_type); end
        total++; if (bus.request_address !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.request_address); end
        total++; if (bus.data_out !== 16'h0) begin bad++; $display("FAIL rst_data_out got=%h exp=0", bus.data_out); end
        total++; if (bus.ch_grant !== 2'b00) begin bad++; $display("FAIL rst_grant got=%b exp=00", bus.ch_grant); end
        total++; if (bus.ch_done !== 2'b00) begin bad++; $display("FAIL rst_done got=%b exp=00", bus.ch_done); end
        total++; if (bus.ch_error !== 1'b0) begin bad++; $display("FAIL rst_error got=%b exp=0", bus.ch_error); end
        total++; if (bus.ch_rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.ch_rdata); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_single_read();
        bus.ch_req = 2'b01;
        bus.ch_addr[15:0] = 16'h1234;
        sbq.push_back(exp_t'{ch: 0, rd: 1'b1, rdata: 16'hBEEF, err: 1'b0});
        cyc();
        total++; if (bus.request !== 1'b1) begin bad++; $display("FAIL rd_request got=%b exp=1", bus.request); end
        total++; if (bus.request_type !== 1'b0) begin bad++; $display("FAIL rd_type got=%b exp=0", bus.request_type); end
        total++; if (bus.request_address !== 16'h1234) begin bad++; $display("FAIL rd_addr got=%h exp=1234", bus.request_address); end
        total++; if (bus.ch_grant !== 2'b01) begin bad++; $display("FAIL rd_grant got=%b exp=01", bus.ch_grant); end
        bus.memory_ready = 1'b1;
        bus.memory_in = 16'hBEEF;
        cyc();
        total++; if (bus.request !== 1'b0) begin bad++; $display("FAIL rd_request_done got=%b exp=0", bus.request); end
        total++; if (bus.ch_done !== 2'b01) begin bad++; $display("FAIL rd_done got=%b exp=01", bus.ch_done); end
        total++; if (bus.ch_grant !== 2'b01) begin bad++; $display("FAIL rd_grant_done got=%b exp=01", bus.ch_grant); end
        idle_inputs();
        cyc();
        total++; if (bus.ch_grant !== 2'b00) begin bad++; $display("FAIL rd_grant_idle got=%b exp=00", bus.ch_grant); end
        total++; if (bus.ch_done !== 2'b00) begin bad++; $display("FAIL rd_done_idle got=%b exp=00", bus.ch_done); end
    endtask

    task automatic test_write();
        bus.ch_req = 2'b10;
        bus.ch_type = 2'b10;
        bus.ch_addr[31:16] = 16'h0010;
        bus.ch_wdata[31:16] = 16'h5A5A;
        sbq.push_back(exp_t'{ch: 1, rd: 1'b0, rdata: 16'h0, err: 1'b0});
        for (int c = 1; c <= 4; c++) begin
            cyc();
            total++; if (bus.request !== 1'b1) begin bad++; $display("FAIL wr_request c=%0d got=%b exp=1", c, bus.request); end
            total++; if (bus.request_type !== 1'b1) begin bad++; $display("FAIL wr_type c=%0d got=%b exp=1", c, bus.request_type); end
            total++; if (bus.data_out !== 16'h5A5A) begin bad++; $display("FAIL wr_data_out c=%0d got=%h exp=5a5a", c, bus.data_out); end
            total++; if (bus.request_address !== 16'h0010) begin bad++; $display("FAIL wr_addr c=%0d got=%h exp=0010", c, bus.request_address); end
            total++; if (bus.ch_grant !== 2'b10) begin bad++; $display("FAIL wr_grant c=%0d got=%b exp=10", c, bus.ch_grant); end
            bus.memory_ready = (c == 2);
            bus.memory_in = 16'hDEAD;
            if (c >= 2) begin
                bus.ch_wdata[31:16] = 16'hFFFF;
                bus.ch_addr[31:16] = 16'hFFFF;
                bus.ch_type = 2'b00;
            end
            bus.write_complete = (c == 4);
        end
        cyc();
        total++; if (bus.ch_done !== 2'b10) begin bad++; $display("FAIL wr_done got=%b exp=10", bus.ch_done); end
        total++; if (bus.request !== 1'b0) begin bad++; $display("FAIL wr_request_done got=%b exp=0", bus.request); end
        total++; if (bus.ch_rdata !== 16'hBEEF) begin bad++; $display("FAIL wr_rdata_kept got=%h exp=beef", bus.ch_rdata); end
        idle_inputs();
        cyc();
        total++; if (bus.ch_grant !== 2'b00) begin bad++; $display("FAIL wr_grant_idle got=%b exp=00", bus.ch_grant); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] oh;
        bus.ch_req = 2'b11;
        bus.ch_addr = {16'hA001, 16'hA000};
        for (int i = 0; i < 4; i++) begin
            oh = 2'b01 << (i % 2);
            sbq.push_back(exp_t'{ch: i % 2, rd: 1'b1, rdata: 16'h1000 + 16'(i), err: 1'b0});
            cyc();
            total++; if (bus.ch_grant !== oh) begin bad++; $display("FAIL rr_grant i=%0d got=%b exp=%b", i, bus.ch_grant, oh); end
            total++; if (bus.request_address !== 16'hA000 + 16'(i % 2)) begin bad++; $display("FAIL rr_addr i=%0d got=%h exp=%h", i, bus.request_address, 16'hA000 + 16'(i % 2)); end
            bus.memory_ready = 1'b1;
            bus.memory_in = 16'h1000 + 16'(i);
            cyc();
            total++; if (bus.ch_done !== oh) begin bad++; $display("FAIL rr_done i=%0d got=%b exp=%b", i, bus.ch_done, oh); end
            bus.memory_ready = 1'b0;
            bus.ch_req = bus.ch_req & ~oh;
            cyc();
            total++; if (bus.request !== 1'b0) begin bad++; $display("FAIL rr_request_idle i=%0d got=%b exp=0", i, bus.request); end
            bus.ch_req = 2'b11;
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_critical();
        bus.memory_critical = 1'b1;
        bus.ch_req = 2'b10;
        bus.ch_addr = {16'hC001, 16'hC000};
        for (int c = 0; c < 3; c++) begin
            cyc();
            total++; if (bus.request !== 1'b0 || bus.ch_grant !== 2'b00) begin bad++; $display("FAIL crit_block c=%0d got req=%b grant=%b exp req=0 grant=00", c, bus.request, bus.ch_grant); end
        end
        bus.ch_req = 2'b11;
        sbq.push_back(exp_t'{ch: 0, rd: 1'b1, rdata: 16'h0C0C, err: 1'b0});
        cyc();
        total++; if (bus.ch_grant !== 2'b01) begin bad++; $display("FAIL crit_grant0 got=%b exp=01", bus.ch_grant); end
        total++; if (bus.request_address !== 16'hC000) begin bad++; $display("FAIL crit_addr0 got=%h exp=c000", bus.request_address); end
        bus.memory_ready = 1'b1;
        bus.memory_in = 16'h0C0C;
        cyc();
        bus.memory_ready = 1'b0;
        bus.ch_req = 2'b10;
        cyc();
        cyc();
        total++; if (bus.request !== 1'b0) begin bad++; $display("FAIL crit_hold_ch1 got=%b exp=0", bus.request); end
        bus.memory_critical = 1'b0;
        sbq.push_back(exp_t'{ch: 1, rd: 1'b1, rdata: 16'hC1C1, err: 1'b0});
        cyc();
        total++; if (bus.ch_grant !== 2'b10) begin bad++; $display("FAIL crit_grant1 got=%b exp=10", bus.ch_grant); end
        total++; if (bus.request_address !== 16'hC001) begin bad++; $display("FAIL crit_addr1 got=%h exp=c001", bus.request_address); end
        bus.memory_critical = 1'b1;
        cyc();
        total++; if (bus.request !== 1'b1 || bus.ch_grant !== 2'b10) begin bad++; $display("FAIL crit_no_abort got req=%b grant=%b exp req=1 grant=10", bus.request, bus.ch_grant); end
        bus.memory_ready = 1'b1;
        bus.memory_in = 16'hC1C1;
        cyc();
        total++; if (bus.ch_done !== 2'b10) begin bad++; $display("FAIL crit_done1 got=%b exp=10", bus.ch_done); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_timeout();
        bus.ch_req = 2'b01;
        bus.ch_addr[15:0] = 16'h2222;
        sbq.push_back(exp_t'{ch: 0, rd: 1'b0, rdata: 16'h0, err: 1'b1});
        for (int c = 1; c <= 4; c++) begin
            cyc();
            total++; if (bus.request !== 1'b1) begin bad++; $display("FAIL to_request c=%0d got=%b exp=1", c, bus.request); end
        end
        cyc();
        total++; if (bus.ch_done !== 2'b01) begin bad++; $display("FAIL to_done got=%b exp=01", bus.ch_done); end
        total++; if (bus.ch_error !== 1'b1) begin bad++; $display("FAIL to_error got=%b exp=1", bus.ch_error); end
        total++; if (bus.ch_rdata !== 16'hC1C1) begin bad++; $display("FAIL to_rdata_kept got=%h exp=c1c1", bus.ch_rdata); end
        bus.ch_req = 2'b00;
        cyc();
        total++; if (bus.ch_error !== 1'b0) begin bad++; $display("FAIL to_error_clear got=%b exp=0", bus.ch_error); end
        bus.ch_req = 2'b01;
        bus.ch_type = 2'b01;
        bus.ch_wdata[15:0] = 16'h3333;
        sbq.push_back(exp_t'{ch: 0, rd: 1'b0, rdata: 16'h0, err: 1'b0});
        for (int c = 1; c <= 4; c++) begin
            cyc();
            total++; if (bus.request !== 1'b1) begin bad++; $display("FAIL to_edge_request c=%0d got=%b exp=1", c, bus.request); end
            bus.write_complete = (c == 4);
        end
        cyc();
        total++; if (bus.ch_done !== 2'b01) begin bad++; $display("FAIL to_edge_done got=%b exp=01", bus.ch_done); end
        total++; if (bus.ch_error !== 1'b0) begin bad++; $display("FAIL to_edge_error got=%b exp=0", bus.ch_error); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_busy();
        bus.ch_req = 2'b01;
        bus.ch_addr[15:0] = 16'h4444;
        cyc();
        total++; if (bus.request !== 1'b1) begin bad++; $display("FAIL rm_request_before got=%b exp=1", bus.request); end
        cyc();
        reset = 1'b0;
        #1;
        total++; if (bus.request !== 1'b0) begin bad++; $display("FAIL rm_request got=%b exp=0", bus.request); end
        total++; if (bus.ch_grant !== 2'b00) begin bad++; $display("FAIL rm_grant got=%b exp=00", bus.ch_grant); end
        total++; if (bus.ch_done !== 2'b00) begin bad++; $display("FAIL rm_done got=%b exp=00", bus.ch_done); end
        cyc();
        bus.ch_req = 2'b11;
        bus.ch_addr = {16'h5555, 16'h4444};
        reset = 1'b1;
        sbq.push_back(exp_t'{ch: 0, rd: 1'b1, rdata: 16'h7777, err: 1'b0});
        cyc();
        total++; if (bus.ch_grant !== 2'b01) begin bad++; $display("FAIL rm_first_ch0 got=%b exp=01", bus.ch_grant); end
        bus.memory_ready = 1'b1;
        bus.memory_in = 16'h7777;
        cyc();
        idle_inputs();
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_back_to_back();
        test_critical();
        test_timeout();
        test_reset_mid_busy();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d pending exp=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/x3q_mem_arbiter.md
# x3q_mem_arbiter

Parametrised memory-port arbiter that multiplexes CHANNELS independent requesters (instruction fetch, data load/store, UART DMA, and so on) onto the single x3q16-style memory handshake (request / request_type / request_address / data_out, with memory_ready / write_complete / memory_in returning). It is the multi-master successor to the single-master CPU memory port. It generalises address and data width and the channel count. It adds round-robin fairness, a memory_critical priority override and a per-transaction timeout with an error report.

## Interface
- DATA_W, 16: data width of memory_in, data_out, channel write/read data.
- ADDR_W, 16: address width.
- CHANNELS, 2: number of requesters, 1..8; channel 0 is the priority channel.
- TIMEOUT, 255: number of BUSY cycles without completion before abort; 0 disables the timeout.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- ch_req, input, CHANNELS: per-channel level request, held until that channel's ch_done.
- ch_type, input, CHANNELS: per-channel type, 0 = read, 1 = write.
- ch_addr, input, CHANNELS*ADDR_W: flattened addresses; channel i occupies [i*ADDR_W +: ADDR_W].
- ch_wdata, input, CHANNELS*DATA_W: flattened write data, same packing.
- ch_grant, output, CHANNELS: one-hot owner during BUSY and DONE; 0 in IDLE.
- ch_done, output, CHANNELS: one-cycle completion pulse to the owner.
- ch_error, output, 1: high together with ch_done when the transaction timed out.
- ch_rdata, output, DATA_W: read data, valid in the ch_done cycle.
- request, output, 1: memory request, held for the whole transaction.
- request_type, output, 1: 0 = read, 1 = write.
- request_address, output, ADDR_W: memory address.
- data_out, output, DATA_W: write data to memory.
- memory_in, input, DATA_W: read data from memory.
- memory_ready, input, 1: read completion.
- write_complete, input, 1: write completion.
- memory_critical, input, 1: when high, only channel 0 may be granted.

## Operation
- FSM states:
  - IDLE: if any channel is eligible, go to BUSY; otherwise stay in IDLE.
  - BUSY: on completion or timeout, go to DONE; otherwise stay in BUSY.
  - DONE: always go to IDLE.
- Grant (IDLE only):
  - Eligible set = ch_req, masked to bit 0 when memory_critical = 1.
  - Round-robin search starts at last_grant+1 mod CHANNELS.
  - last_grant resets to CHANNELS-1, so channel 0 wins first after reset.
- On IDLE→BUSY:
  - Latch ch_type, ch_addr and ch_wdata of the winner into request_type, request_address and data_out.
  - Set ch_grant and last_grant.
  - Clear the timeout counter.
- Latched values are stable for the whole transaction; changes on the channel inputs during BUSY are ignored.
- Completion in BUSY:
  - Read: memory_ready = 1. Capture memory_in into ch_rdata.
  - Write: write_complete = 1.
  - The completion strobe of the opposite type is ignored.
- Timeout:
  - The counter increments each BUSY cycle.
  - If TIMEOUT ≠ 0 and TIMEOUT BUSY cycles elapse with no completion, go to DONE with ch_error = 1. ch_rdata is not updated on timeout.
  - Completion in the same cycle the count reaches TIMEOUT wins, so ch_error = 0.
- DONE state:
  - request = 0.
  - ch_done[owner] = 1 and ch_grant[owner] = 1.
  - The owner must drop ch_req at the edge ending DONE, or it is re-arbitrated.
- memory_critical:
  - Sampled only in IDLE.
  - It never aborts an in-flight transaction of another channel.
  - With memory_critical = 1 and ch_req[0] = 0, the arbiter stays in IDLE.
- CHANNELS = 1: channel 0 is always the winner; round-robin logic is trivial.

## Timing
- Reset values (asynchronous, while reset = 0):
  - state IDLE.
  - request, request_type, request_address, data_out = 0.
  - ch_grant, ch_done, ch_error, ch_rdata = 0.
  - last_grant = CHANNELS-1.
- Reset mid-transaction drops request immediately; no ch_done is issued.
- All outputs are registered.
- Cycle sequence:
  - ch_req sampled in cycle 0 (IDLE).
  - request = 1 from cycle 1.
  - Completion strobe in cycle k≥1 gives DONE in cycle k+1 (request = 0, ch_done = 1).
  - IDLE in cycle k+2.
- Minimum latency ch_req → ch_done is 2 cycles; back-to-back grants are spaced by 3 cycles.
- A timeout with TIMEOUT = T gives DONE in cycle T+1 relative to grant cycle 0.

## Test plan
- Single read, ch 0, addr 0x1234, memory_ready in cycle 1 with memory_in = 0xBEEF → request high for cycle 1 only, request_type = 0, request_address = 0x1234; ch_done[0] and ch_rdata = 0xBEEF in cycle 2.
- Write on ch 1, addr 0x0010, wdata 0x5A5A, write_complete after 4 cycles; a memory_ready pulse mid-transaction → memory_ready ignored; data_out = 0x5A5A throughout; ch_done[1] one cycle after write_complete.
- Both channels holding ch_req continuously (CHANNELS = 2) → grants alternate 0, 1, 0, 1; each ch_done lands on the correct channel.
- memory_critical = 1 with ch 1 pending and ch 0 idle → no request; raising ch_req[0] → ch 0 granted; ch 1 is granted after memory_critical drops.
- TIMEOUT = 4, no completion → ch_done and ch_error in cycle 5. Repeat with write_complete in BUSY cycle 4 → ch_error = 0.
- reset deasserted→asserted mid-BUSY → request, ch_grant and ch_done are 0 immediately; after release, channel 0 has first priority.
